// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Responder end of the MEM-stage data-memory interface. Accepts
//                one load/store at a time, answers it a fixed LATENCY cycles
//                later from a word-addressed register array, and stalls the
//                pipeline while the access is outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_stall
);

   localparam int         c_DEPTH  = 2 ** ADDR_WIDTH;
   localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic [3:0]              r_count;
   logic                    r_write;
   logic                    r_err;
   logic [ADDR_WIDTH-1:0]   r_index;
   logic [31:0]             r_wdata;
   logic [31:0]             r_mem [c_DEPTH];

   logic                    w_accept;
   logic                    w_commit;
   logic                    w_unused_addr;

   // A request is taken only in IDLE; inputs outside IDLE are never looked at.
   assign w_accept = (r_state == ST_IDLE) && req_valid;

   // Stores land on the edge that ends RESP, and only when the access is aligned.
   assign w_commit = (r_state == ST_RESP) && r_write && !r_err;

   // Address bits above the word index are deliberately ignored (addresses wrap).
   assign w_unused_addr = &{1'b0, req_addr[31:ADDR_WIDTH+2]};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_count == 4'd1) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Latency counter: loaded on acceptance, counts down through WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= 4'd0;
      end else if (w_accept) begin
         r_count <= c_LAT_M1;
      end else if (r_state == ST_WAIT) begin
         r_count <= r_count - 4'd1;
      end
   end

   // Latched copy of the accepted request; the outstanding access uses only this.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_index <= '0;
         r_wdata <= 32'd0;
      end else if (w_accept) begin
         r_write <= req_write;
         r_err   <= (req_addr[1:0] != 2'b00);
         r_index <= req_addr[ADDR_WIDTH+1:2];
         r_wdata <= req_wdata;
      end
   end

   // Backing store: cleared on reset; a reset in RESP drops the pending store.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= 32'd0;
         end
      end else if (w_commit) begin
         r_mem[r_index] <= r_wdata;
      end
   end

   // Handshake and response outputs; data/error are forced to zero outside RESP.
   always_comb begin
      req_ready  = (r_state == ST_IDLE);
      mem_stall  = w_accept || (r_state == ST_WAIT);
      resp_valid = (r_state == ST_RESP);
      resp_err   = resp_valid && r_err;
      resp_rdata = 32'd0;
      if (resp_valid && !r_write && !r_err) begin
         resp_rdata = r_mem[r_index];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder. One instance at
//                LATENCY = 2 takes directed and random requests; a second at
//                LATENCY = 1 sees a continuously asserted req_valid. Expected
//                responses come from a plain word-array model of memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

   localparam int LAT_A = 2;
   localparam int LAT_B = 1;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;

   logic        a_valid, a_write, a_ready, a_resp_valid, a_err, a_stall;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        b_valid, b_write, b_ready, b_resp_valid, b_err, b_stall;
   logic [31:0] b_addr, b_wdata, b_rdata;

   logic [31:0] model_a [DEPTH];
   logic [31:0] model_b [DEPTH];

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT_A)) u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (a_valid),
      .req_write  (a_write),
      .req_addr   (a_addr),
      .req_wdata  (a_wdata),
      .req_ready  (a_ready),
      .resp_valid (a_resp_valid),
      .resp_rdata (a_rdata),
      .resp_err   (a_err),
      .mem_stall  (a_stall)
   );

   data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT_B)) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (b_valid),
      .req_write  (b_write),
      .req_addr   (b_addr),
      .req_wdata  (b_wdata),
      .req_ready  (b_ready),
      .resp_valid (b_resp_valid),
      .resp_rdata (b_rdata),
      .resp_err   (b_err),
      .mem_stall  (b_stall)
   );

   // Single comparison point: counts every check and reports any miss.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Random address: word index in [0, max_idx], random high bits, sometimes misaligned.
   function automatic logic [31:0] rand_addr(input int max_idx);
      logic [31:0] a;
      a = 32'($urandom_range(0, max_idx)) * 32'd4;
      a = a + ($urandom & 32'hFFFF_FC00);
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      return a;
   endfunction

   // One request on instance A, checked cycle by cycle against the model.
   task automatic a_req(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got);
      int          idx;
      logic        err;
      logic [31:0] exp;
      idx = int'((addr / 32'd4) % DEPTH);
      err = (addr % 32'd4) != 32'd0;
      exp = (!w && !err) ? model_a[idx] : 32'd0;
      got = 32'd0;
      @(negedge clk);
      a_valid = 1'b1; a_write = w; a_addr = addr; a_wdata = wdata;
      #1;
      check("a_ready_on_req", 32'(a_ready), 32'd1);
      check("a_stall_on_req", 32'(a_stall), 32'd1);
      check("a_no_resp_on_req", 32'(a_resp_valid), 32'd0);
      for (int k = 1; k <= LAT_A; k++) begin
         @(negedge clk);
         // Scramble the request lines: the outstanding access must not notice.
         a_valid = 1'b0; a_write = 1'($urandom); a_addr = $urandom; a_wdata = $urandom;
         #1;
         if (k < LAT_A) begin
            check("a_wait_valid", 32'(a_resp_valid), 32'd0);
            check("a_wait_stall", 32'(a_stall), 32'd1);
            check("a_wait_rdata", a_rdata, 32'd0);
         end else begin
            check("a_resp_valid", 32'(a_resp_valid), 32'd1);
            check("a_resp_rdata", a_rdata, exp);
            check("a_resp_err", 32'(a_err), 32'(err));
            check("a_resp_stall", 32'(a_stall), 32'd0);
            check("a_resp_ready", 32'(a_ready), 32'd0);
            got = a_rdata;
         end
      end
      if (w && !err) model_a[idx] = wdata;
   endtask

   task automatic clear_models();
      for (int i = 0; i < DEPTH; i++) begin
         model_a[i] = 32'd0;
         model_b[i] = 32'd0;
      end
   endtask

   initial begin
      logic [31:0] got;
      logic        p_w;
      logic [31:0] p_addr, p_wdata;
      logic        p_err;
      int          p_idx;

      rst = 1'b1;
      a_valid = 1'b0; a_write = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
      b_valid = 1'b0; b_write = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
      clear_models();

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
      check("rst_rdata", a_rdata, 32'd0);
      check("rst_err", 32'(a_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("idle_ready", 32'(a_ready), 32'd1);
      check("idle_stall", 32'(a_stall), 32'd0);

      // Directed accesses.
      a_req(1'b0, 32'h0000_0010, 32'd0, got);
      check("load_0x10_zero", got, 32'h0000_0000);
      a_req(1'b1, 32'h0000_0024, 32'hDEAD_BEEF, got);
      a_req(1'b0, 32'h0000_0024, 32'd0, got);
      check("raw_0x24", got, 32'hDEAD_BEEF);
      a_req(1'b0, 32'h0000_0020, 32'd0, got);
      check("neighbour_0x20", got, 32'h0000_0000);
      a_req(1'b1, 32'h0000_0404, 32'h1234_5678, got);
      a_req(1'b0, 32'h0000_0004, 32'd0, got);
      check("wrap_0x04", got, 32'h1234_5678);
      a_req(1'b1, 32'h0000_0026, 32'hFFFF_FFFF, got);
      a_req(1'b0, 32'h0000_0024, 32'd0, got);
      check("misaligned_no_write", got, 32'hDEAD_BEEF);
      a_req(1'b0, 32'h0000_0023, 32'd0, got);

      // Reset while a store sits in WAIT: nothing responds, nothing is written.
      @(negedge clk);
      a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h0000_0040; a_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      a_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_wait_no_resp", 32'(a_resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_no_resp", 32'(a_resp_valid), 32'd0);
      check("post_rst_ready", 32'(a_ready), 32'd1);
      clear_models();
      a_req(1'b0, 32'h0000_0040, 32'd0, got);
      check("dropped_store", got, 32'd0);
      a_req(1'b0, 32'h0000_0024, 32'd0, got);
      check("mem_cleared", got, 32'd0);

      // Random traffic on a small window of words to exercise read-after-write.
      for (int n = 0; n < 40; n++) begin
         a_req(1'($urandom), rand_addr(15), $urandom, got);
      end

      // LATENCY = 1 instance with req_valid held high: accept, respond, accept, ...
      p_w = 1'b0; p_addr = 32'd0; p_wdata = 32'd0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         b_valid = 1'b1; b_write = 1'($urandom); b_addr = rand_addr(7); b_wdata = $urandom;
         #1;
         if ((i % 2) == 0) begin
            check("b_idle_ready", 32'(b_ready), 32'd1);
            check("b_idle_stall", 32'(b_stall), 32'd1);
            check("b_idle_no_resp", 32'(b_resp_valid), 32'd0);
            p_w = b_write; p_addr = b_addr; p_wdata = b_wdata;
         end else begin
            p_err = (p_addr % 32'd4) != 32'd0;
            p_idx = int'((p_addr / 32'd4) % DEPTH);
            check("b_resp_valid", 32'(b_resp_valid), 32'd1);
            check("b_resp_ready", 32'(b_ready), 32'd0);
            check("b_resp_stall", 32'(b_stall), 32'd0);
            check("b_resp_err", 32'(b_err), 32'(p_err));
            check("b_resp_rdata", b_rdata, (!p_w && !p_err) ? model_b[p_idx] : 32'd0);
            if (p_w && !p_err) model_b[p_idx] = p_wdata;
         end
      end
      @(negedge clk);
      b_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
